// File: rtl/tt_um_suba_pkg.sv
// Shared constants and FSM state type for the tt_um_suba SPI block.
package tt_um_suba_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic [DATA_W-1:0] MATCH_BYTE_DEF = 8'hAC;
  localparam logic [DATA_W-1:0] TX_BYTE_DEF    = 8'h5A;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/tt_um_suba_spi_sclk_gen.sv
// SPI clock divider: toggles sclk every CLK_DIV enabled cycles and flags each toggle
// with single-cycle rise/fall strobes that coincide with the toggling edge.
module spi_sclk_gen #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

  logic [7:0] r_div;
  logic       r_sclk;
  logic       w_tick;

  assign w_tick = i_en && (r_div == DivLast);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_en) begin
      r_div  <= '0;
      r_sclk <= 1'b0;
    end else if (w_tick) begin
      r_div  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_div <= r_div + 8'd1;
    end
  end

  assign o_sclk = r_sclk;
  assign o_rise = w_tick & ~r_sclk;
  assign o_fall = w_tick & r_sclk;

endmodule

// File: rtl/tt_um_suba.sv
// SPI slave that generates its own sclk, shifts a byte each way while cs is low and
// lights led on MATCH_BYTE. Define SPI_LOOPBACK_EN to echo the last received byte on miso.
module tt_um_suba
  import tt_um_suba_pkg::*;
#(
  parameter int unsigned        CLK_DIV    = 1,
  parameter logic [DATA_W-1:0]  MATCH_BYTE = MATCH_BYTE_DEF,
  parameter logic [DATA_W-1:0]  TX_BYTE    = TX_BYTE_DEF
) (
  input  logic clock_in,
  input  logic rs,
  input  logic cs,
  input  logic mosi,
  output logic sclk,
  output logic miso,
  output logic led
);

  state_e            r_state;
  state_e            w_state_next;
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx_byte;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_seen;
  logic [DATA_W-1:0] w_tx_load;
  logic              w_sclk_en;
  logic              w_sclk;
  logic              w_rise;
  logic              w_fall;

  // Divider only runs while actually shifting; dropping cs stops it at once.
  assign w_sclk_en = (r_state == StShift) && !cs;

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .i_clk   (clock_in),
    .i_rst_n (rs),
    .i_en    (w_sclk_en),
    .o_sclk  (w_sclk),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

`ifdef SPI_LOOPBACK_EN
  // In DONE the freshly received byte is reloaded before it lands in r_rx_byte.
  assign w_tx_load = (r_state == StDone) ? r_rx : r_rx_byte;
`else
  assign w_tx_load = TX_BYTE;
`endif

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (!cs) w_state_next = StShift;
      end
      StShift: begin
        if (cs) begin
          w_state_next = StIdle;
        end else if (w_fall && (r_cnt == CNT_W'(DATA_W))) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        w_state_next = cs ? StIdle : StShift;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clock_in or negedge rs) begin
    if (!rs) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock_in or negedge rs) begin
    if (!rs) begin
      r_rx      <= '0;
      r_tx      <= '0;
      r_rx_byte <= '0;
      r_cnt     <= '0;
      r_seen    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_rx  <= '0;
          r_cnt <= '0;
          if (!cs) r_tx <= w_tx_load;
        end
        StShift: begin
          if (cs) begin
            r_rx  <= '0;
            r_tx  <= '0;
            r_cnt <= '0;
          end else begin
            if (w_rise) begin
              r_rx  <= {r_rx[DATA_W-2:0], mosi};
              r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_fall) r_tx <= {r_tx[DATA_W-2:0], 1'b0};
          end
        end
        StDone: begin
          r_rx_byte <= r_rx;
          r_seen    <= 1'b1;
          r_rx      <= '0;
          r_cnt     <= '0;
          r_tx      <= cs ? '0 : w_tx_load;
        end
        default: ;
      endcase
    end
  end

  assign sclk = w_sclk;
  assign miso = r_tx[DATA_W-1];
  // r_seen keeps led low after reset even if MATCH_BYTE is 0x00.
  assign led  = r_seen && (r_rx_byte == MATCH_BYTE);

endmodule

// File: tb/tb_tt_um_suba.sv
// Randomized self-checking bench for tt_um_suba against a per-byte transaction model.
module tb_tt_um_suba;

  localparam int unsigned CLK_DIV = 1;
  localparam logic [7:0]  MATCH   = 8'hAC;
  localparam logic [7:0]  TXB     = 8'h5A;

  logic clock_in = 1'b0;
  logic rs       = 1'b1;
  logic cs       = 1'b1;
  logic mosi     = 1'b0;
  logic sclk;
  logic miso;
  logic led;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Model state: led level and last completed byte.
  logic       m_led  = 1'b0;
  logic [7:0] m_prev = 8'h00;

  always #5 clock_in = ~clock_in;

  tt_um_suba #(
    .CLK_DIV    (CLK_DIV),
    .MATCH_BYTE (MATCH),
    .TX_BYTE    (TXB)
  ) dut (
    .clock_in (clock_in),
    .rs       (rs),
    .cs       (cs),
    .mosi     (mosi),
    .sclk     (sclk),
    .miso     (miso),
    .led      (led)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  function automatic logic [7:0] tx_expect();
`ifdef SPI_LOOPBACK_EN
    return m_prev;
`else
    return TXB;
`endif
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_sclk"}, 8'(sclk), 8'h0);
    check({tag, "_miso"}, 8'(miso), 8'h0);
    check({tag, "_led"}, 8'(led), 8'(m_led));
  endtask

  // One sclk half-period; sclk only changes on its last clock.
  task automatic half(input logic lvl, input string tag);
    for (int i = 0; i < int'(CLK_DIV); i++) begin
      step();
      check(tag, 8'(sclk), (i == int'(CLK_DIV) - 1) ? 8'(lvl) : 8'(~lvl));
    end
  endtask

  task automatic xfer_bits(input logic [7:0] b, input logic [7:0] tx, input int nbits);
    logic [7:0] sh;
    for (int k = 0; k < nbits; k++) begin
      mosi = b[7-k];
      half(1'b1, "sclk_rise");
      sh = tx << k;
      check("miso_hold", 8'(miso), 8'(sh[7]));
      mosi = 1'($urandom);
      half(1'b0, "sclk_fall");
      sh = tx << (k + 1);
      check("miso_next", 8'(miso), 8'(sh[7]));
      check("led_mid", 8'(led), 8'(m_led));
    end
  endtask

  task automatic start_frame();
    cs = 1'b0;
    step();
    check("start_sclk", 8'(sclk), 8'h0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    logic [7:0] tx;
    tx = tx_expect();
    check("miso_load", 8'(miso), 8'(tx[7]));
    xfer_bits(b, tx, 8);
    if (last) cs = 1'b1;
    step();
    m_led  = (b == MATCH);
    m_prev = b;
    check("led_done", 8'(led), 8'(m_led));
    check("done_sclk", 8'(sclk), 8'h0);
    if (last) check("end_miso", 8'(miso), 8'h0);
  endtask

  task automatic abort_byte(input logic [7:0] b, input int nbits);
    logic [7:0] tx;
    tx = tx_expect();
    check("miso_load", 8'(miso), 8'(tx[7]));
    xfer_bits(b, tx, nbits);
    cs = 1'b1;
    step();
    check_idle("abort");
  endtask

  task automatic reset_mid(input logic [7:0] b, input int nbits);
    logic [7:0] tx;
    tx = tx_expect();
    xfer_bits(b, tx, nbits);
    #3 rs = 1'b0;
    #1;
    m_led  = 1'b0;
    m_prev = 8'h00;
    check_idle("rst_async");
    cs = 1'b1;
    step();
    check_idle("rst_held");
    #2 rs = 1'b1;
    step();
    check_idle("rst_rel");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int         n;
    int         mode;

    #1 rs = 1'b0;
    #9;
    check_idle("por");
    #1 rs = 1'b1;
    repeat (5) begin
      step();
      check_idle("idle_hold");
    end

    // Single matching byte.
    start_frame();
    send_byte(8'hAC, 1'b1);
    check("led_ac", 8'(led), 8'h1);
    step();
    check_idle("post_ac");

    // Non-match then match back to back.
    start_frame();
    send_byte(8'h3C, 1'b0);
    check("led_3c", 8'(led), 8'h0);
    send_byte(8'hAC, 1'b1);
    check("led_b2b", 8'(led), 8'h1);

    // Second byte carries TX_BYTE or the echoed first byte.
    start_frame();
    send_byte(8'hAC, 1'b0);
    send_byte(8'h00, 1'b1);
    check("led_00", 8'(led), 8'h0);

    // Aborts keep led; a following full byte still counts.
    start_frame();
    send_byte(8'hAC, 1'b1);
    start_frame();
    abort_byte(8'hAC, 4);
    check("led_abort_keep1", 8'(led), 8'h1);
    start_frame();
    send_byte(8'h3C, 1'b1);
    start_frame();
    abort_byte(8'hAC, 4);
    check("led_abort_keep0", 8'(led), 8'h0);
    start_frame();
    send_byte(8'hAC, 1'b1);
    check("led_after_abort", 8'(led), 8'h1);

    // Asynchronous reset mid-byte.
    start_frame();
    reset_mid(8'hAC, 3);

    repeat (40) begin
      mode = int'($urandom_range(0, 9));
      n    = int'($urandom_range(1, 3));
      start_frame();
      for (int i = 0; i < n; i++) begin
        b = ($urandom_range(0, 3) == 0) ? MATCH : 8'($urandom);
        if (i == n - 1 && mode == 0) begin
          abort_byte(b, int'($urandom_range(0, 7)));
        end else if (i == n - 1 && mode == 1) begin
          reset_mid(b, int'($urandom_range(0, 7)));
        end else begin
          send_byte(b, i == n - 1);
        end
      end
      repeat ($urandom_range(0, 3)) begin
        mosi = 1'($urandom);
        step();
        check_idle("gap");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tt_um_suba.md
TT_UM_SUBA -- requirements
Module: tt_um_suba

Interface
REQ-001 Parameter CLK_DIV, default 1: number of clock_in cycles per sclk half-period; legal range 1..255.
REQ-002 Parameter MATCH_BYTE, default 8'hAC: received byte value that lights led.
REQ-003 Parameter TX_BYTE, default 8'h5A: byte shifted out on miso when loopback is compiled out.
REQ-004 clock_in  input  1  sole clock; all state changes on its rising edge.
REQ-005 rs  input  1  reset, asynchronous, active-low.
REQ-006 cs  input  1  chip select, active-low; frames a transfer.
REQ-007 mosi  input  1  serial data in, MSB first.
REQ-008 sclk  output  1  generated SPI clock, idle low (mode 0).
REQ-009 miso  output  1  serial data out, MSB first.
REQ-010 led  output  1  high while the last complete byte received equals MATCH_BYTE.

Function
REQ-011 The block SHALL be an SPI master-clocked slave: it generates sclk itself and shifts data while cs is low.
REQ-012 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-013 IDLE: sclk=0, bit counter=0, divider=0, miso=0.
REQ-014 IDLE->SHIFT when cs is sampled low; same edge loads the 8-bit tx register and drives miso = tx[7].
REQ-015 In SHIFT, sclk SHALL toggle every CLK_DIV clock_in cycles (CLK_DIV=1: sclk period 2 cycles, 8 bits in 16 cycles).
REQ-016 On each sclk rising toggle, mosi SHALL be shifted into rx register LSB, MSB first, and the bit counter incremented.
REQ-017 On each sclk falling toggle, tx SHALL shift left and miso SHALL present the next bit.
REQ-018 After the 8th rising toggle plus the following falling toggle, FSM SHALL enter DONE for exactly one cycle.
REQ-019 DONE: rx latched into rx_byte; led <= (rx_byte == MATCH_BYTE); tx reloaded; counter cleared.
REQ-020 DONE->SHIFT if cs still low (back-to-back bytes, no gap); DONE->IDLE if cs high.
REQ-021 cs high during SHIFT SHALL abort within one cycle: go to IDLE, discard partial byte, led unchanged.
REQ-022 led SHALL hold its value until the next DONE or reset.
REQ-023 mosi is sampled synchronously; no metastability filtering required.

Reset
REQ-024 rs low SHALL asynchronously force IDLE, sclk=0, miso=0, led=0, rx/tx/rx_byte/counters=0.
REQ-025 Reset release SHALL take effect on the next clock_in rising edge; reset mid-transfer discards the byte.

Configuration
REQ-026 Macro SPI_LOOPBACK_EN defined: tx register SHALL load the previous rx_byte (0x00 after reset).
REQ-027 SPI_LOOPBACK_EN undefined: tx register SHALL load TX_BYTE.

Structure
REQ-028 Package tt_um_suba_pkg SHALL hold DATA_W=8, the FSM state enum, and default MATCH_BYTE/TX_BYTE constants.
REQ-029 Sub-module spi_sclk_gen SHALL implement the divider and emit sclk plus one-cycle rise/fall strobes; top holds FSM and shift registers.

Verification
REQ-030 rs low 10 ns, then high with cs high -> sclk=0, miso=0, led=0 held indefinitely.
REQ-031 cs low, mosi bits 1,0,1,0,1,1,0,0 aligned to sclk rise, CLK_DIV=1 -> rx_byte=0xAC, led=1 one cycle after 8th fall.
REQ-032 Send 0x3C -> led=0; then send 0xAC without raising cs -> led=1, no idle gap between bytes.
REQ-033 Loopback build: send 0xAC, then 0x00 -> miso carries 1,0,1,0,1,1,0,0 during second byte; non-loopback -> 0x5A.
REQ-034 cs high after 4 bits of 0xAC -> IDLE, sclk=0, led keeps prior value; next full 0xAC -> led=1.
REQ-035 rs low mid-byte -> all outputs 0 immediately (asynchronous, before next clock edge).
